// File: rtl/trace_pkg.sv
// Shared types and entry-field layout for the CPU instruction-trace buffer.
// An entry is packed as {cycle, pc, ir, regs}, with register channel 0 in the LSBs.
package trace_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_POST  = 2'd2,
      ST_DONE  = 2'd3
   } trace_state_t;

   typedef enum logic [1:0] {
      MODE_FREE = 2'd0,
      MODE_FILL = 2'd1,
      MODE_TRIG = 2'd2
   } trace_mode_t;

   function automatic int regs_lsb();
      return 0;
   endfunction

   function automatic int ir_lsb(input int reg_ch);
      return 8 * reg_ch;
   endfunction

   function automatic int pc_lsb(input int reg_ch, input int ir_w);
      return 8 * reg_ch + ir_w;
   endfunction

   function automatic int cyc_lsb(input int reg_ch, input int ir_w, input int pc_w);
      return 8 * reg_ch + ir_w + pc_w;
   endfunction

   function automatic int entry_width(input int reg_ch, input int ir_w, input int pc_w,
                                      input int cyc_w);
      return 8 * reg_ch + ir_w + pc_w + cyc_w;
   endfunction

   // The reserved encoding 3 runs as free-running capture.
   function automatic trace_mode_t decode_mode(input logic [1:0] m);
      case (m)
         2'd1:    return MODE_FILL;
         2'd2:    return MODE_TRIG;
         default: return MODE_FREE;
      endcase
   endfunction

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port trace memory: one write port, one registered read port.
// A read and write to the same address in one cycle returns the old contents.
module trace_ram #(
   parameter int  DEPTH = 256,
   parameter int  WIDTH = 8,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             re_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/cpu_trace_buffer.sv
// Instruction-trace capture: one entry per instruction boundary into a circular
// buffer, with free-run, fill-once and PC-triggered capture and a synchronous read port.
module cpu_trace_buffer
   import trace_pkg::*;
#(
   parameter int  DEPTH   = 256,
   parameter int  PC_W    = 16,
   parameter int  IR_W    = 8,
   parameter int  REG_CH  = 8,
   parameter int  CYC_W   = 32,
   localparam int ENTRY_W = CYC_W + PC_W + IR_W + 8 * REG_CH,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                sample,
   input  logic [PC_W-1:0]     pc,
   input  logic [IR_W-1:0]     ir,
   input  logic [8*REG_CH-1:0] regs,
   input  logic [1:0]          mode,
   input  logic                arm,
   input  logic                abort,
   input  logic [PC_W-1:0]     trig_pc,
   input  logic [AW-1:0]       post_count,
   input  logic                rd_en,
   input  logic [AW-1:0]       rd_idx,
   output logic                rd_valid,
   output logic [ENTRY_W-1:0]  rd_data,
   output logic [1:0]          state,
   output logic [AW:0]         count,
   output logic                triggered,
   output logic [CYC_W-1:0]    cycles
);

   localparam logic [AW:0] FULL    = (AW+1)'(DEPTH);
   localparam int          IR_LSB  = ir_lsb(REG_CH);
   localparam int          PC_LSB  = pc_lsb(REG_CH, IR_W);
   localparam int          CYC_LSB = cyc_lsb(REG_CH, IR_W, PC_W);

   trace_state_t       state_q, state_d;
   trace_mode_t        mode_q, mode_d;
   logic [AW-1:0]      post_q, post_d;
   logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]        count_q, count_d;
   logic               trig_q, trig_d;
   logic [CYC_W-1:0]   cyc_q;
   logic               rd_valid_q;
   logic               rd_hit_q;
   logic               wr_en;
   logic               rd_hit;
   logic [AW-1:0]      rd_addr;
   logic [ENTRY_W-1:0] wr_entry;
   logic [ENTRY_W-1:0] ram_rdata;

   always_comb begin
      wr_entry = '0;
      wr_entry[regs_lsb() +: 8*REG_CH] = regs;
      wr_entry[IR_LSB +: IR_W]         = ir;
      wr_entry[PC_LSB +: PC_W]         = pc;
      wr_entry[CYC_LSB +: CYC_W]       = cyc_q;
   end

   // post_count is AW bits wide, so it can never exceed DEPTH-1 and needs no clamp.
   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      post_d   = post_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      trig_d   = trig_q;
      wr_en    = 1'b0;
      if (abort) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (arm) begin
                  state_d  = ST_ARMED;
                  mode_d   = decode_mode(mode);
                  post_d   = post_count;
                  wr_ptr_d = '0;
                  count_d  = '0;
                  trig_d   = 1'b0;
               end
            end
            ST_ARMED: begin
               if (sample) begin
                  wr_en    = 1'b1;
                  wr_ptr_d = wr_ptr_q + 1'b1;
                  if (count_q != FULL) begin
                     count_d = count_q + 1'b1;
                  end
                  case (mode_q)
                     MODE_FILL: begin
                        if (count_q == FULL - 1'b1) begin
                           state_d = ST_DONE;
                        end
                     end
                     MODE_TRIG: begin
                        if (pc == trig_pc) begin
                           trig_d  = 1'b1;
                           state_d = (post_q == '0) ? ST_DONE : ST_POST;
                        end
                     end
                     default: ;
                  endcase
               end
            end
            ST_POST: begin
               if (sample) begin
                  wr_en    = 1'b1;
                  wr_ptr_d = wr_ptr_q + 1'b1;
                  post_d   = post_q - 1'b1;
                  if (count_q != FULL) begin
                     count_d = count_q + 1'b1;
                  end
                  if (post_q == AW'(1)) begin
                     state_d = ST_DONE;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Logical index 0 is the oldest valid entry, count_q slots behind the write pointer.
   assign rd_addr = wr_ptr_q - count_q[AW-1:0] + rd_idx;
   assign rd_hit  = {1'b0, rd_idx} < count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         mode_q     <= MODE_FREE;
         post_q     <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         trig_q     <= 1'b0;
         cyc_q      <= '0;
         rd_valid_q <= 1'b0;
         rd_hit_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         post_q     <= post_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         trig_q     <= trig_d;
         cyc_q      <= cyc_q + 1'b1;
         rd_valid_q <= rd_en;
         rd_hit_q   <= rd_en & rd_hit;
      end
   end

   trace_ram #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_ram (
      .clk     (clk),
      .we_i    (wr_en & ~rst),
      .waddr_i (wr_ptr_q),
      .wdata_i (wr_entry),
      .re_i    (rd_en & ~rst),
      .raddr_i (rd_addr),
      .rdata_o (ram_rdata)
   );

   // The RAM is never cleared, so out-of-range and post-reset reads are masked to zero.
   assign rd_data   = rd_hit_q ? ram_rdata : '0;
   assign rd_valid  = rd_valid_q;
   assign state     = state_q;
   assign count     = count_q;
   assign triggered = trig_q;
   assign cycles    = cyc_q;

endmodule

// File: doc/cpu_trace_buffer.md
# cpu_trace_buffer

Synthesizable, parametrised instruction-trace capture for the GameBoy CPU. It records one entry per instruction boundary into a circular buffer, and supports free-run, fill-once and PC-triggered capture modes. It sits beside the datapath, fed by its PC/IR/register outputs and a fetch strobe from the control path. It is read back over a synchronous read port, which replaces bench-only cycle counting and monitoring with hardware that works on silicon.

## Interface
- DEPTH, 256, entries in buffer; power of two, ≥ 4
- PC_W, 16, program-counter width
- IR_W, 8, instruction-register width
- REG_CH, 8, number of 8-bit register channels captured (A,B,C,D,E,F,H,L order)
- CYC_W, 32, cycle-stamp width
- ENTRY_W, CYC_W+PC_W+IR_W+8*REG_CH, derived; not overridden
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- sample  in  1  instruction-boundary strobe; one entry per high cycle when capturing
- pc  in  PC_W  PC of the instruction being sampled
- ir  in  IR_W  opcode being sampled
- regs  in  REG_CH×8  register snapshot
- mode  in  2  0 FREE, 1 FILL, 2 TRIG, 3 reserved (treated as FREE); sampled on arm
- arm  in  1  start a capture
- abort  in  1  stop capture, keep contents
- trig_pc  in  PC_W  trigger address (TRIG mode)
- post_count  in  $clog2(DEPTH)  samples kept after the trigger sample; sampled on arm
- rd_en  in  1  read request
- rd_idx  in  $clog2(DEPTH)  logical index; 0 = oldest valid entry
- rd_valid  out  1  read data valid
- rd_data  out  ENTRY_W  {cycle, pc, ir, regs}; regs[0] in the LSBs
- state  out  2  IDLE/ARMED/POST/DONE
- count  out  $clog2(DEPTH)+1  valid entries, 0..DEPTH
- triggered  out  1  trigger seen this capture
- cycles  out  CYC_W  free-running cycle counter

## Operation
- Cycle counter: increments every clk after reset and wraps modulo 2^CYC_W. An entry stores the value present in the cycle `sample` is high.
- States:
  - IDLE → ARMED on `arm`. The arm clears `count`, the write pointer and `triggered`, and latches `mode` and `post_count`.
  - ARMED: each `sample` writes at wr_ptr. Then wr_ptr = (wr_ptr+1) mod DEPTH and count = min(count+1, DEPTH).
    - FREE: stays ARMED, overwriting the oldest entry.
    - FILL: → DONE on the write that makes count = DEPTH.
    - TRIG: stays ARMED and wraps until `sample` arrives with pc == trig_pc. That sample is written, `triggered` is set, and the state goes to POST. If the latched post_count = 0, it goes to DONE instead.
  - POST: writes post_count samples after the trigger sample, then → DONE. The trigger entry plus the post-window entries never exceed DEPTH. If post_count ≥ DEPTH−1, it is clamped to DEPTH−1.
  - DONE: no writes. `arm` re-arms.
  - `abort` in any state → IDLE with no write that cycle. Contents and `count` are kept. abort beats arm when both are high.
- `arm` while ARMED/POST (without abort) is ignored.
- A `sample` in IDLE or DONE is ignored.
- Read port:
  - Physical address = (wr_ptr − count + rd_idx) mod DEPTH.
  - If rd_idx ≥ count, rd_data = 0 but rd_valid is still asserted.
  - Reads are legal in every state, including while writing. A same-address write and read returns the old data (read-before-write).

## Timing
- Reset values: state IDLE, count 0, triggered 0, cycles 0, rd_valid 0, rd_data 0, wr_ptr 0. RAM contents are not cleared; they are unreadable because count = 0.
- Write latency: an entry sampled in cycle n is readable by an rd_en in cycle n+1. Its count/state updates are visible at n+1.
- Read latency: rd_en in cycle n → rd_valid/rd_data in n+1. rd_valid drops the cycle after rd_en drops. Back-to-back reads give one result per cycle.
- `arm` in cycle n → state ARMED at n+1. A `sample` in cycle n is not captured.
- rst mid-capture: all outputs return to reset values the next cycle. No write occurs in the reset cycle.

## Structure
- `trace_pkg` holds `trace_state_t` (IDLE, ARMED, POST, DONE), `trace_mode_t` (FREE, FILL, TRIG), and the entry-field offset functions used by both RTL and bench.
- Sub-module `trace_ram`: simple dual-port memory, one write and one synchronous read, read-before-write, parametrised by DEPTH and width. The FSM, pointers, counter and address arithmetic live in `cpu_trace_buffer`.

## Test plan
- Reset then read: rst for 2 cycles, then rd_en with rd_idx = 0 → rd_valid = 1, rd_data = 0, count = 0, state IDLE, cycles counting from 0.
- FILL with DEPTH = 4: arm mode 1, 6 samples with pc = 0x0100..0x0105.
  - After the 4th sample: state DONE, count 4.
  - Reads of idx 0..3 return pc 0x0100..0x0103.
  - Cycle stamps are strictly increasing and match `cycles` at sample time.
- FREE wrap with DEPTH = 4: 6 samples pc 0x0200..0x0205 → count 4; idx 0 = 0x0202, idx 3 = 0x0205; state stays ARMED.
- TRIG: trig_pc = 0x0150, post_count = 2, DEPTH = 8. Samples 0x0140..0x0160 step 1.
  - DONE after pc 0x0152.
  - triggered = 1, count = 8.
  - idx 5 = 0x0150, idx 7 = 0x0152.
- Simultaneous events:
  - arm+abort in IDLE → stays IDLE.
  - abort in the same cycle as a sample in ARMED → no write, state IDLE, count unchanged.
  - TRIG with post_count = 0 → DONE right after the matching sample.
- Reset mid-POST: rst during POST → state IDLE, count 0, triggered 0 next cycle. A subsequent arm and capture behave as from cold reset.
